// File: rtl/up_counter_ctrl.sv
// Timer-style up counter controller: start/stop/pause sequencing, prescaled advance,
// one-shot or auto-reload wrap, with tick/done/busy status.
module up_counter_ctrl #(
    parameter int N          = 4,
    parameter int PRESCALE_W = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  pause,
    input  logic                  auto_reload,
    input  logic [N-1:0]          limit,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic [N-1:0]          count,
    output logic                  tick,
    output logic                  done,
    output logic                  busy,
    output logic [1:0]            state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_HOLD = 2'b10,
        ST_DONE = 2'b11
    } state_t;

    state_t                  state_q, state_d;
    logic [N-1:0]            count_q, count_d;
    logic [PRESCALE_W-1:0]   pc_q, pc_d;
    logic                    tick_q, tick_d;
    logic [N-1:0]            limit_q, limit_d;
    logic [PRESCALE_W-1:0]   prescale_q, prescale_d;
    logic                    auto_q, auto_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            pc_q       <= '0;
            tick_q     <= 1'b0;
            limit_q    <= '0;
            prescale_q <= '0;
            auto_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            pc_q       <= pc_d;
            tick_q     <= tick_d;
            limit_q    <= limit_d;
            prescale_q <= prescale_d;
            auto_q     <= auto_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        pc_d       = pc_q;
        tick_d     = 1'b0;
        limit_d    = limit_q;
        prescale_d = prescale_q;
        auto_d     = auto_q;

        if (stop) begin
            state_d = ST_IDLE;
            count_d = '0;
            pc_d    = '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (state_q == ST_IDLE) begin
                        count_d = '0;
                        pc_d    = '0;
                    end
                    if (start) begin
                        state_d    = ST_RUN;
                        count_d    = '0;
                        pc_d       = '0;
                        limit_d    = limit;
                        prescale_d = prescale;
                        auto_d     = auto_reload;
                    end
                end
                ST_RUN: begin
                    // Pause takes the edge: no advance even when the prescaler is due.
                    if (pause) begin
                        state_d = ST_HOLD;
                    end else if (pc_q != prescale_q) begin
                        pc_d = pc_q + 1'b1;
                    end else begin
                        pc_d = '0;
                        if (count_q != limit_q) begin
                            count_d = count_q + 1'b1;
                        end else begin
                            tick_d = 1'b1;
                            if (auto_q) begin
                                count_d = '0;
                            end else begin
                                state_d = ST_DONE;
                            end
                        end
                    end
                end
                ST_HOLD: begin
                    if (!pause) begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign count = count_q;
    assign tick  = tick_q;
    assign state = state_q;
    assign done  = (state_q == ST_DONE);
    assign busy  = (state_q == ST_RUN) || (state_q == ST_HOLD);

endmodule
